// File: rtl/conv_win_pkg.sv
// conv_win_pkg: shared width helpers and frame configuration type for conv_window_gen.
package conv_win_pkg;
    localparam int CFG_W = 16;
    localparam int STR_W = 8;

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int addr_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

    function automatic int win_w(input int kr, input int kc, input int ch, input int dw);
        return kr * kc * ch * dw;
    endfunction

    // Fields are wide enough for any supported frame; the top zero-extends its config ports.
    typedef struct packed {
        logic [CFG_W-1:0] cols;
        logic [CFG_W-1:0] rows;
        logic [STR_W-1:0] stride;
    } frame_cfg_t;
endpackage

// File: rtl/conv_window_gen_if.sv
// conv_window_gen_if: pixel-in / window-out valid-ready bundle.
interface conv_window_gen_if
    import conv_win_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int WIN_W = win_w(3, 3, 1, 8)
);
    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIN_W-1:0] out_window;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport slave (input in_data, in_valid, out_ready, output in_ready, out_window, out_valid, out_last);
    modport master (output in_data, in_valid, out_ready, input in_ready, out_window, out_valid, out_last);
endinterface

// File: rtl/conv_line_mem.sv
// conv_line_mem: simple dual-port read-first line memory with 1-cycle registered read.
module conv_line_mem
    import conv_win_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2048,
    localparam int AW   = addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             re,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
        if (re) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming K_ROWS x K_COLS multi-channel window generator with runtime stride.
// Define CONV_WIN_PERF_CNT_EN to add the win_count / stall_count performance counters.
module conv_window_gen
    import conv_win_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_COLS   = 2048,
    parameter int MAX_ROWS   = 2048,
    parameter int K_ROWS     = 3,
    parameter int K_COLS     = 3,
    parameter int CHANNELS   = 1,
    parameter int MAX_STRIDE = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [cnt_w(MAX_COLS)-1:0]  frame_cols,
    input  logic [cnt_w(MAX_ROWS)-1:0]  frame_rows,
    input  logic [cnt_w(MAX_STRIDE)-1:0] stride,
`ifdef CONV_WIN_PERF_CNT_EN
    output logic [31:0]                 win_count,
    output logic [31:0]                 stall_count,
`endif
    conv_window_gen_if.slave            bus
);
    localparam int PW = CHANNELS * DATA_WIDTH;
    localparam int AW = addr_w(MAX_COLS);
    localparam int EW = CFG_W + 1;
    localparam logic [CFG_W-1:0] ONE   = CFG_W'(1);
    localparam logic [STR_W-1:0] S_ONE = STR_W'(1);

    frame_cfg_t cfg, cfg_q;
    logic [CFG_W-1:0] col, row, col_nxt, row_nxt;
    logic [STR_W-1:0] cphase, rphase, cp, rp, s;
    logic acc, eol, eof, emit, last;
    logic [K_ROWS-2:0][PW-1:0] rd;
    logic [K_ROWS-1:0][PW-1:0] lin;
    logic [K_ROWS-1:0][K_COLS-1:0][PW-1:0] sr, sr_nxt;

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign acc = bus.in_valid && bus.in_ready;
    assign lin = {rd, bus.in_data};

    // Config is taken live on pixel (0,0) and held for the rest of the frame.
    always_comb begin
        cfg     = (col == '0 && row == '0) ? {CFG_W'(frame_cols), CFG_W'(frame_rows), STR_W'(stride)} : cfg_q;
        s       = cfg.stride == '0 ? S_ONE : cfg.stride;
        eol     = col == cfg.cols - ONE;
        eof     = eol && row == cfg.rows - ONE;
        col_nxt = eol ? '0 : col + ONE;
        row_nxt = eof ? '0 : (eol ? row + ONE : row);
        cp      = col == CFG_W'(K_COLS - 1) ? '0 : cphase;
        rp      = row == CFG_W'(K_ROWS - 1) ? '0 : rphase;
        emit    = col >= CFG_W'(K_COLS - 1) && row >= CFG_W'(K_ROWS - 1) && cp == '0 && rp == '0;
        last    = EW'(col) + EW'(s) >= EW'(cfg.cols) && EW'(row) + EW'(s) >= EW'(cfg.rows);
    end

    // lin[0] is the incoming row; lin[i+1] is line i, so row tap r (0 = oldest) is lin[K_ROWS-1-r].
    for (genvar r = 0; r < K_ROWS; r++) begin : g_row
        assign sr_nxt[r][K_COLS-1] = lin[K_ROWS-1-r];
        for (genvar c = 0; c < K_COLS - 1; c++) begin : g_col
            assign sr_nxt[r][c] = sr[r][c+1];
        end
    end

    // Lines read one column ahead so the registered read data lines up with the next accepted pixel.
    for (genvar i = 0; i < K_ROWS - 1; i++) begin : g_line
        conv_line_mem #(.WIDTH(PW), .DEPTH(MAX_COLS)) u_line (
            .clk     (clk),
            .we      (acc),
            .wr_addr (col[AW-1:0]),
            .wr_data (lin[i]),
            .re      (acc),
            .rd_addr (col_nxt[AW-1:0]),
            .rd_data (rd[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col            <= '0;
            row            <= '0;
            cphase         <= '0;
            rphase         <= '0;
            cfg_q          <= '0;
            sr             <= '0;
            bus.out_valid  <= 1'b0;
            bus.out_last   <= 1'b0;
            bus.out_window <= '0;
        end else begin
            if (acc) begin
                col    <= col_nxt;
                row    <= row_nxt;
                cfg_q  <= cfg;
                sr     <= sr_nxt;
                cphase <= cp == s - S_ONE ? '0 : cp + S_ONE;
                if (eol) rphase <= rp == s - S_ONE ? '0 : rp + S_ONE;
            end
            if (acc && emit) begin
                bus.out_window <= sr_nxt;
                bus.out_last   <= last;
            end
            bus.out_valid <= (acc && emit) || (bus.out_valid && !bus.out_ready);
        end
    end

`ifdef CONV_WIN_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_count   <= '0;
            stall_count <= '0;
        end else begin
            if (bus.out_valid && bus.out_ready && ~&win_count) win_count <= win_count + 32'd1;
            if (bus.out_valid && !bus.out_ready && ~&stall_count) stall_count <= stall_count + 32'd1;
        end
    end
`endif
endmodule
